// File: rtl/usb_uart_readback_tx.sv
// Fabric-to-host readback path: buffers 32-bit words in a FIFO and sends them
// to the host as framed byte streams: 00 AA FF TAG N <payload MSB-first> XOR.
module usb_uart_readback_tx #(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned FRAME_WORDS     = 8,
  parameter logic [7:0]  TAG             = 8'h03
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [31:0]                word_data_i,
  input  logic                       word_valid_i,
  output logic                       word_ready_o,
  input  logic                       flush_i,
  output logic [7:0]                 in_data_o,
  output logic                       in_valid_o,
  input  logic                       in_ready_i,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level_o,
  output logic                       busy_o
);

  localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;
  localparam int unsigned LvlW  = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {StIdle, StHdr, StLen, StPay, StCsum} state_e;

  logic [31:0]                mem_q [Depth];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [LvlW-1:0]            level_q;
  state_e                     state_q, state_d;
  logic                       flush_q, flush_d;
  logic [7:0]                 n_q, n_d, word_cnt_q, word_cnt_d;
  logic [1:0]                 byte_cnt_q, byte_cnt_d;
  logic [7:0]                 csum_q, csum_d, data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       push, pop, accept, launch, lvl_ge_frame;
  logic [31:0]                head_word, next_word;

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    hdr_byte = 8'h00;
      2'd1:    hdr_byte = 8'hAA;
      2'd2:    hdr_byte = 8'hFF;
      default: hdr_byte = TAG;
    endcase
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    word_byte = w[31:24];
      2'd1:    word_byte = w[23:16];
      2'd2:    word_byte = w[15:8];
      default: word_byte = w[7:0];
    endcase
  endfunction

  assign word_ready_o = (level_q != LvlW'(Depth));
  assign push         = word_valid_i && word_ready_o;
  assign accept       = valid_q && in_ready_i;
  // The word leaves the FIFO only once its last byte is taken by the host.
  assign pop          = accept && (state_q == StPay) && (byte_cnt_q == 2'd3);
  assign rd_ptr_nxt   = rd_ptr_q + FIFO_DEPTH_LOG2'(1);
  assign head_word    = mem_q[rd_ptr_q];
  assign next_word    = mem_q[rd_ptr_nxt];
  assign lvl_ge_frame = (32'(level_q) >= FRAME_WORDS);
  assign launch       = (state_q == StIdle) && (lvl_ge_frame || (flush_q && (level_q != '0)));

  assign in_data_o    = data_q;
  assign in_valid_o   = valid_q;
  assign fifo_level_o = level_q;
  assign busy_o       = (state_q != StIdle);

  // Word storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= word_data_i;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
      if (pop)  rd_ptr_q <= rd_ptr_nxt;
      if (push && !pop)      level_q <= level_q + LvlW'(1);
      else if (!push && pop) level_q <= level_q - LvlW'(1);
    end
  end

  // Framer next-state and output-register logic.
  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q | flush_i;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    data_d     = data_q;
    valid_d    = valid_q;
    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (launch) begin
          n_d        = lvl_ge_frame ? 8'(FRAME_WORDS) : 8'(level_q);
          csum_d     = 8'h00;
          byte_cnt_d = 2'd0;
          data_d     = hdr_byte(2'd0);
          valid_d    = 1'b1;
          state_d    = StHdr;
          flush_d    = flush_i;
        end else if (level_q == '0) begin
          // Nothing to send: a pending flush is dropped.
          flush_d = flush_i;
        end
      end
      StHdr: begin
        if (accept) begin
          if (byte_cnt_q == 2'd3) begin
            state_d = StLen;
            data_d  = n_q;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            data_d     = hdr_byte(byte_cnt_q + 2'd1);
          end
        end
      end
      StLen: begin
        if (accept) begin
          state_d    = StPay;
          word_cnt_d = 8'd0;
          byte_cnt_d = 2'd0;
          data_d     = head_word[31:24];
        end
      end
      StPay: begin
        if (accept) begin
          csum_d = csum_q ^ data_q;
          if (byte_cnt_q != 2'd3) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            data_d     = word_byte(head_word, byte_cnt_q + 2'd1);
          end else if (word_cnt_q == n_q - 8'd1) begin
            state_d = StCsum;
            data_d  = csum_q ^ data_q;
          end else begin
            // Head is popped on this edge, so the following word is the next entry.
            word_cnt_d = word_cnt_q + 8'd1;
            byte_cnt_d = 2'd0;
            data_d     = next_word[31:24];
          end
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  // Framer state and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      flush_q    <= 1'b0;
      n_q        <= 8'd0;
      word_cnt_q <= 8'd0;
      byte_cnt_q <= 2'd0;
      csum_q     <= 8'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_usb_uart_readback_tx.sv
// Scoreboard bench for usb_uart_readback_tx: stimulus builds expected frames from the
// words it pushes; a negedge monitor checks every accepted byte and the handshake rules.
module tb_usb_uart_readback_tx;

  localparam int FrameWords = 8;
  localparam int Depth      = 16;

  typedef struct {
    logic [7:0] data;
    bit         last;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [31:0] word_data_i = '0;
  logic        word_valid_i = 1'b0;
  logic        word_ready_o;
  logic        flush_i = 1'b0;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i = 1'b0;
  logic [4:0]  fifo_level_o;
  logic        busy_o;

  int          n_checks = 0;
  int          n_fail = 0;
  int          ready_mode = 1;   // 0 low, 1 high, 2 random
  int          accepted = 0;
  exp_t        exp_q[$];
  logic [31:0] model_q[$];
  bit          hold_chk = 0;
  bit          gap_chk = 0;
  logic [7:0]  hold_data = '0;

  usb_uart_readback_tx #(
    .FIFO_DEPTH_LOG2(4),
    .FRAME_WORDS    (FrameWords),
    .TAG            (8'h03)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .word_data_i (word_data_i),
    .word_valid_i(word_valid_i),
    .word_ready_o(word_ready_o),
    .flush_i     (flush_i),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .fifo_level_o(fifo_level_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a frame is the header, N, each word's bytes MSB-first, then the XOR.
  task automatic emit_frame(input int n);
    logic [7:0] b, x;
    logic [31:0] w;
    exp_t e;
    x = 8'h00;
    e.last = 0;
    e.data = 8'h00; exp_q.push_back(e);
    e.data = 8'hAA; exp_q.push_back(e);
    e.data = 8'hFF; exp_q.push_back(e);
    e.data = 8'h03; exp_q.push_back(e);
    e.data = 8'(n); exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      w = model_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        b = 8'((w >> (8 * (3 - k))) & 32'hFF);
        x = x ^ b;
        e.data = b;
        exp_q.push_back(e);
      end
    end
    e.data = x;
    e.last = 1;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is taken.
  task automatic push_word(input logic [31:0] w);
    int t;
    bit ok;
    t = 0;
    ok = 0;
    word_data_i = w;
    word_valid_i = 1'b1;
    while (!ok && t < 3000) begin
      @(negedge clk_i);
      if (word_ready_o) ok = 1;
      else t++;
    end
    if (ok) begin
      model_q.push_back(w);
      if (model_q.size() >= FrameWords) emit_frame(FrameWords);
    end else begin
      check(0, "push_timeout", 32'(t), 32'd0);
    end
    @(posedge clk_i); #1;
    word_valid_i = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    if (model_q.size() > 0) emit_frame(model_q.size());
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Wait until every expected byte is consumed and the framer is idle.
  task automatic drain();
    int t;
    t = 0;
    @(negedge clk_i);
    while ((exp_q.size() != 0 || busy_o || in_valid_o) && t < 5000) begin
      @(negedge clk_i);
      t++;
    end
    check(t < 5000, "drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk_i); #1;
  endtask

  // Host-side ready driver.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      case (ready_mode)
        0:       in_ready_i = 1'b0;
        1:       in_ready_i = 1'b1;
        default: in_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: byte scoreboard, hold-under-backpressure, no bubbles, one-cycle gap.
  always @(negedge clk_i) begin
    exp_t e;
    if (!reset_n_i) begin
      hold_chk = 0;
      gap_chk  = 0;
    end else begin
      if (gap_chk) begin
        check(in_valid_o == 1'b0, "gap_after_csum", 32'(in_valid_o), 32'd0);
        gap_chk = 0;
      end
      if (hold_chk)
        check(in_valid_o && in_data_o == hold_data, "hold_stable", {23'd0, in_valid_o, in_data_o},
              {24'd1, hold_data});
      if (busy_o) check(in_valid_o == 1'b1, "no_bubble", 32'(in_valid_o), 32'd1);
      if (in_valid_o && in_ready_i) begin
        accepted++;
        if (exp_q.size() == 0) begin
          check(0, "unexpected_byte", 32'(in_data_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check(in_data_o == e.data, "stream_byte", 32'(in_data_o), 32'(e.data));
          if (e.last) gap_chk = 1;
        end
      end
      hold_chk  = in_valid_o && !in_ready_i;
      hold_data = in_data_o;
    end
  end

  initial begin
    #300_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, t, n;
    // Reset values.
    #12;
    check(in_valid_o == 0, "rst_valid", 32'(in_valid_o), 32'd0);
    check(in_data_o == 0, "rst_data", 32'(in_data_o), 32'd0);
    check(busy_o == 0, "rst_busy", 32'(busy_o), 32'd0);
    check(fifo_level_o == 0, "rst_level", 32'(fifo_level_o), 32'd0);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check(word_ready_o == 1, "rst_word_ready", 32'(word_ready_o), 32'd1);

    // Single word, flushed.
    ready_mode = 1;
    push_word(32'h1122_3344);
    pulse_flush();
    drain();
    check(fifo_level_o == 0, "t1_level", 32'(fifo_level_o), 32'd0);
    check(busy_o == 0, "t1_busy", 32'(busy_o), 32'd0);

    // Eight words launch a frame on their own; then again under random backpressure.
    for (int pass = 0; pass < 2; pass++) begin
      ready_mode = pass == 0 ? 1 : 2;
      for (int i = 0; i < 8; i++) push_word(32'(i));
      drain();
      check(fifo_level_o == 0, "t2_level", 32'(fifo_level_o), 32'd0);
    end

    // Fill the FIFO with the host stalled.
    ready_mode = 0;
    wait_cycles(2);
    for (int i = 0; i < 16; i++) push_word(32'hA000_0000 + 32'(i));
    @(negedge clk_i);
    check(fifo_level_o == 5'(Depth), "full_level", 32'(fifo_level_o), 32'(Depth));
    check(word_ready_o == 0, "full_not_ready", 32'(word_ready_o), 32'd0);
    @(posedge clk_i); #1;
    word_data_i = 32'hDEAD_BEEF;
    word_valid_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      check(word_ready_o == 0, "full_reject", 32'(word_ready_o), 32'd0);
    end
    @(posedge clk_i); #1;
    word_valid_i = 1'b0;
    check(fifo_level_o == 5'(Depth), "full_level_hold", 32'(fifo_level_o), 32'(Depth));
    ready_mode = 1;
    t = 0;
    while (!word_ready_o && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    check(word_ready_o == 1 && fifo_level_o == 5'(Depth - 1), "ready_rises",
          32'(fifo_level_o), 32'(Depth - 1));
    @(posedge clk_i); #1;
    drain();
    check(fifo_level_o == 0, "t4_level", 32'(fifo_level_o), 32'd0);

    // Flush on an empty FIFO sends nothing and does not linger.
    pulse_flush();
    wait_cycles(5);
    push_word(32'hCAFE_F00D);
    wait_cycles(20);
    check(in_valid_o == 0 && busy_o == 0, "no_stale_flush", {in_valid_o, busy_o}, 32'd0);
    check(fifo_level_o == 1, "one_buffered", 32'(fifo_level_o), 32'd1);
    pulse_flush();
    drain();

    // Reset in the middle of a frame's payload.
    push_word(32'h0102_0304);
    push_word(32'h0506_0708);
    push_word(32'h090A_0B0C);
    start = accepted;
    pulse_flush();
    t = 0;
    while (accepted < start + 7 && t < 200) begin
      @(posedge clk_i);
      t++;
    end
    #2;
    reset_n_i = 1'b0;
    exp_q.delete();
    model_q.delete();
    #1;
    check(in_valid_o == 0, "midrst_valid", 32'(in_valid_o), 32'd0);
    check(fifo_level_o == 0, "midrst_level", 32'(fifo_level_o), 32'd0);
    wait_cycles(3);
    #1;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    push_word(32'h5566_7788);
    pulse_flush();
    drain();

    // Randomized traffic with random backpressure.
    for (int r = 0; r < 6; r++) begin
      ready_mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        push_word($urandom);
        wait_cycles($urandom_range(0, 2));
      end
      drain();
      check(32'(fifo_level_o) == model_q.size(), "rand_level", 32'(fifo_level_o),
            32'(model_q.size()));
      pulse_flush();
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
